// File: rtl/tetris_pkg.sv
// Shared piece definitions and LFSR tap selection for the piece generators.
package tetris_pkg;

  localparam int NUM_PIECE_TYPES = 7;
  localparam int PIECE_ID_W      = 3;

  typedef logic [PIECE_ID_W-1:0] piece_t;

  // Piece identities as produced by the generator.
  localparam piece_t I = 3'd0;
  localparam piece_t O = 3'd1;
  localparam piece_t T = 3'd2;
  localparam piece_t S = 3'd3;
  localparam piece_t Z = 3'd4;
  localparam piece_t J = 3'd5;
  localparam piece_t L = 3'd6;

  // Feedback mask for a right-shifting Fibonacci LFSR; bit k of the mask is
  // the state bit (width - tap) for the classic tap list of each width.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return 32'h0000_001D;  // taps 8,6,5,4
      16:      return 32'h0000_002D;  // taps 16,14,13,11
      24:      return 32'h0000_0087;  // taps 24,23,22,17
      32:      return 32'hC000_0401;  // taps 32,22,2,1
      default: return 32'h0000_002D;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_n.sv
// Right-shifting Fibonacci LFSR with synchronous load. A zero load value is
// replaced by SEED so the register can never enter the all-zero lock-up state.
module lfsr_n #(
  parameter int           W    = 16,
  parameter logic [W-1:0] SEED = 16'hACE1,
  parameter logic [W-1:0] TAPS = 16'h002D
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] state
);

  // Shift toward the LSB every cycle; feedback enters at the MSB.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= SEED;
    end else if (load) begin
      state <= (load_value == '0) ? SEED : load_value;
    end else begin
      state <= {^(state & TAPS), state[W-1:1]};
    end
  end

endmodule

// File: rtl/bag_randomizer.sv
// Bag-rule piece generator with a ready/pop queue and a lookahead preview.
// Each draw folds the low LFSR bits into a candidate type; in bag mode the
// first unused type at or after the candidate (wrapping) is taken instead.
module bag_randomizer
  import tetris_pkg::*;
#(
  parameter int                NUM_TYPES = NUM_PIECE_TYPES,
  parameter int                PIECE_W   = PIECE_ID_W,
  parameter int                PREVIEW   = 3,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic                         seed_load,
  input  logic [LFSR_W-1:0]            seed,
  input  logic                         bag_mode,
  input  logic                         pop,
  output logic                         valid,
  output logic [PIECE_W-1:0]           next_piece,
  output logic [PREVIEW*PIECE_W-1:0]   preview,
  output logic [7:0]                   bag_count
);

  localparam int DEPTH = PREVIEW + 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int EXT_W = PIECE_W + 1;

  localparam logic [EXT_W-1:0]     NT_EXT    = EXT_W'(NUM_TYPES);
  localparam logic [OCC_W-1:0]     DEPTH_OCC = OCC_W'(DEPTH);
  localparam logic [NUM_TYPES-1:0] ALL_USED  = '1;
  localparam logic [LFSR_W-1:0]    TAPS      = LFSR_W'(lfsr_taps(LFSR_W));

  logic [LFSR_W-1:0]              lfsr_state;
  logic [DEPTH-1:0][PIECE_W-1:0]  queue;
  logic [OCC_W-1:0]               occupancy;
  logic [NUM_TYPES-1:0]           used;
  logic [NUM_TYPES-1:0]           used_next;
  logic [EXT_W-1:0]               cand_ext;
  logic [EXT_W-1:0]               scan_best;
  logic [EXT_W-1:0]               scan_dist;
  logic [EXT_W-1:0]               scan_t;
  logic [PIECE_W-1:0]             cand;
  logic [PIECE_W-1:0]             bag_pick;
  logic [PIECE_W-1:0]             draw;
  logic                           room;
  logic                           pop_ok;
  logic                           append;
  logic                           bag_done;

  lfsr_n #(
    .W    (LFSR_W),
    .SEED (SEED),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk        (clk),
    .nreset     (nreset),
    .load       (seed_load),
    .load_value (seed),
    .state      (lfsr_state)
  );

  // Fold the raw slice into 0..NUM_TYPES-1; one subtraction is enough
  // because the raw range is less than twice the type count.
  always_comb begin
    cand_ext = {1'b0, lfsr_state[PIECE_W-1:0]};
    if (cand_ext >= NT_EXT) begin
      cand_ext = cand_ext - NT_EXT;
    end
  end

  assign cand = cand_ext[PIECE_W-1:0];

  // Bag pick: the unused type with the smallest forward distance from cand.
  // The mask is cleared as soon as it fills, so some type is always free.
  always_comb begin
    scan_best = NT_EXT;
    scan_dist = '0;
    scan_t    = '0;
    bag_pick  = cand;
    for (int t = 0; t < NUM_TYPES; t++) begin
      scan_t = EXT_W'(t);
      if (scan_t >= cand_ext) begin
        scan_dist = scan_t - cand_ext;
      end else begin
        scan_dist = scan_t + NT_EXT - cand_ext;
      end
      if (!used[t] && (scan_dist < scan_best)) begin
        scan_best = scan_dist;
        bag_pick  = scan_t[PIECE_W-1:0];
      end
    end
  end

  assign draw   = bag_mode ? bag_pick : cand;
  assign valid  = (occupancy == DEPTH_OCC);
  assign room   = (occupancy < DEPTH_OCC);
  assign pop_ok = pop && valid;
  assign append = room || pop_ok;

  // Mark the appended type; a full mask wraps to empty and closes the bag.
  always_comb begin
    used_next = used;
    bag_done  = 1'b0;
    if (append && bag_mode) begin
      used_next = used | (NUM_TYPES'(1) << draw);
      if (used_next == ALL_USED) begin
        used_next = '0;
        bag_done  = 1'b1;
      end
    end
  end

  // Queue: shift-and-append on pop, otherwise fill the first empty slot.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      queue     <= '0;
      occupancy <= '0;
    end else if (seed_load) begin
      queue     <= '0;
      occupancy <= '0;
    end else if (pop_ok) begin
      queue <= {draw, queue[DEPTH-1:1]};
    end else if (room) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (occupancy == OCC_W'(i)) begin
          queue[i] <= draw;
        end
      end
      occupancy <= occupancy + 1'b1;
    end
  end

  // Bag bookkeeping; a reseed discards the partial bag but keeps the count.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      used      <= '0;
      bag_count <= '0;
    end else if (seed_load) begin
      used <= '0;
    end else begin
      used      <= used_next;
      bag_count <= bag_count + {7'd0, bag_done};
    end
  end

  assign next_piece = queue[0];
  assign preview    = queue[DEPTH-1:1];

  // Reset, load and zero-seed substitution together keep the LFSR off zero.
  a_lfsr_nonzero: assert property (@(posedge clk) disable iff (!nreset) lfsr_state != '0);

endmodule

// File: tb/tb_bag_randomizer.sv
// Directed bench for bag_randomizer: hand-computed post-reset vectors, reseed
// replay, bag permutation groups, random mode and a 5-type/1-preview instance.
module tb_bag_randomizer;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic        bag_mode = 1'b1;
  logic        pop = 1'b0;
  logic        valid;
  logic [2:0]  next_piece;
  logic [8:0]  preview;
  logic [7:0]  bag_count;

  logic        nreset_b = 1'b0;
  logic        seed_load_b = 1'b0;
  logic [15:0] seed_b = 16'h0000;
  logic        bag_mode_b = 1'b1;
  logic        pop_b = 1'b0;
  logic        valid_b;
  logic [2:0]  next_b;
  logic [2:0]  preview_b;
  logic [7:0]  bag_count_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       pop;
    logic       exp_valid;
    logic       chk_data;
    logic [2:0] exp_next;
    logic [8:0] exp_prev;
    logic [7:0] exp_bag;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  bag_randomizer #(
    .NUM_TYPES (7),
    .PIECE_W   (3),
    .PREVIEW   (3),
    .LFSR_W    (16),
    .SEED      (16'hACE1)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .seed_load  (seed_load),
    .seed       (seed),
    .bag_mode   (bag_mode),
    .pop        (pop),
    .valid      (valid),
    .next_piece (next_piece),
    .preview    (preview),
    .bag_count  (bag_count)
  );

  bag_randomizer #(
    .NUM_TYPES (5),
    .PIECE_W   (3),
    .PREVIEW   (1),
    .LFSR_W    (16),
    .SEED      (16'hACE1)
  ) dut_b (
    .clk        (clk),
    .nreset     (nreset_b),
    .seed_load  (seed_load_b),
    .seed       (seed_b),
    .bag_mode   (bag_mode_b),
    .pop        (pop_b),
    .valid      (valid_b),
    .next_piece (next_b),
    .preview    (preview_b),
    .bag_count  (bag_count_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Apply the post-reset vector table; bag counts are relative to base.
  task automatic run_vectors(input logic [7:0] base, input string tag);
    for (int i = 0; i < 10; i++) begin
      pop = vecs[i].pop;
      step();
      chk($sformatf("%s_valid_%0d", tag, i), {31'd0, valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("%s_bag_%0d", tag, i), {24'd0, bag_count}, {24'd0, 8'(base + vecs[i].exp_bag)});
      if (vecs[i].chk_data) begin
        chk($sformatf("%s_next_%0d", tag, i), {29'd0, next_piece}, {29'd0, vecs[i].exp_next});
        chk($sformatf("%s_prev_%0d", tag, i), {23'd0, preview}, {23'd0, vecs[i].exp_prev});
      end
    end
    pop = 1'b0;
  endtask

  // Reseed, pop 70 pieces, and check bag groups, preview lookahead and count.
  task automatic perm_run(input logic [15:0] s);
    logic [2:0] got[70];
    logic [8:0] pv[70];
    logic [7:0] seen;
    logic [7:0] b0;
    int n;
    seed = s;
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    chk($sformatf("perm_%0h_valid_after_load", s), {31'd0, valid}, 32'd0);
    b0 = bag_count;
    n = 0;
    for (int cyc = 0; cyc < 200 && n < 70; cyc++) begin
      if (valid) begin
        got[n] = next_piece;
        pv[n]  = preview;
        n++;
        pop = 1'b1;
      end else begin
        pop = 1'b0;
      end
      step();
    end
    pop = 1'b0;
    chk($sformatf("perm_%0h_pop_count", s), n, 70);
    for (int g = 0; g < 10; g++) begin
      seen = '0;
      for (int k = 0; k < 7; k++) seen[got[g*7+k]] = 1'b1;
      chk($sformatf("perm_%0h_group_%0d", s, g), {24'd0, seen}, 32'h7F);
    end
    for (int k = 0; k < 5; k++) begin
      for (int j = 1; j <= 3; j++) begin
        chk($sformatf("perm_%0h_preview_%0d_%0d", s, k, j),
            {29'd0, pv[k][(j-1)*3 +: 3]}, {29'd0, got[k+j]});
      end
    end
    chk($sformatf("perm_%0h_bag_delta", s), {24'd0, 8'(bag_count - b0)}, 32'd10);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 3'd0, 9'h000, 8'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 3'd0, 9'h000, 8'd0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 3'd0, 9'h000, 8'd0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 3'd1, 9'h110, 8'd0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 3'd0, 9'h1A2, 8'd0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 3'd2, 9'h0F4, 8'd0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 3'd4, 9'h15E, 8'd1};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 3'd6, 9'h06B, 8'd1};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 3'd3, 9'h10D, 8'd1};
    vecs[9] = '{1'b0, 1'b1, 1'b1, 3'd3, 9'h10D, 8'd1};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_next", {29'd0, next_piece}, 32'd0);
    chk("reset_preview", {23'd0, preview}, 32'd0);
    chk("reset_bag", {24'd0, bag_count}, 32'd0);
    nreset = 1'b1;
    run_vectors(8'd0, "post_reset");

    // Zero-seed reload together with pop: pop ignored, sequence replays.
    seed = 16'h0000;
    seed_load = 1'b1;
    pop = 1'b1;
    step();
    seed_load = 1'b0;
    pop = 1'b0;
    chk("reload_valid", {31'd0, valid}, 32'd0);
    chk("reload_bag_kept", {24'd0, bag_count}, 32'd1);
    run_vectors(8'd1, "reload");

    perm_run(16'h0001);
    perm_run(16'hFFFF);

    // Uniform mode: no bag accounting, repeats allowed.
    begin
      logic [7:0] b0;
      logic [2:0] last;
      int n;
      int bad;
      int rep;
      bag_mode = 1'b0;
      b0 = bag_count;
      n = 0;
      bad = 0;
      rep = 0;
      last = 3'd7;
      for (int cyc = 0; cyc < 1100 && n < 1000; cyc++) begin
        if (valid) begin
          if (next_piece > 3'd6) bad++;
          if (n > 0 && next_piece == last) rep++;
          last = next_piece;
          n++;
          pop = 1'b1;
        end else begin
          pop = 1'b0;
        end
        step();
      end
      pop = 1'b0;
      chk("mode0_pop_count", n, 1000);
      chk("mode0_out_of_range", bad, 0);
      chk("mode0_repeat_seen", {31'd0, rep > 0}, 32'd1);
      chk("mode0_bag_unchanged", {24'd0, bag_count}, {24'd0, b0});
      bag_mode = 1'b1;
    end

    // Asynchronous reset in the middle of a pop cycle.
    pop = 1'b1;
    #2 nreset = 1'b0;
    #1;
    chk("midreset_valid", {31'd0, valid}, 32'd0);
    chk("midreset_next", {29'd0, next_piece}, 32'd0);
    chk("midreset_preview", {23'd0, preview}, 32'd0);
    chk("midreset_bag", {24'd0, bag_count}, 32'd0);
    pop = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    run_vectors(8'd0, "after_midreset");

    // Five types, one preview slot: depth two.
    chk("b_reset_valid", {31'd0, valid_b}, 32'd0);
    chk("b_reset_bag", {24'd0, bag_count_b}, 32'd0);
    nreset_b = 1'b1;
    step();
    chk("b_valid_edge1", {31'd0, valid_b}, 32'd0);
    step();
    chk("b_valid_edge2", {31'd0, valid_b}, 32'd1);
    begin
      logic [2:0] got[25];
      logic [7:0] seen;
      int n;
      n = 0;
      for (int cyc = 0; cyc < 100 && n < 25; cyc++) begin
        if (valid_b) begin
          got[n] = next_b;
          n++;
          pop_b = 1'b1;
        end else begin
          pop_b = 1'b0;
        end
        step();
      end
      pop_b = 1'b0;
      chk("b_pop_count", n, 25);
      for (int g = 0; g < 5; g++) begin
        seen = '0;
        for (int k = 0; k < 5; k++) seen[got[g*5+k]] = 1'b1;
        chk($sformatf("b_group_%0d", g), {24'd0, seen}, 32'h1F);
      end
      chk("b_bag_count", {24'd0, bag_count_b}, 32'd5);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
